// File: rtl/my_svi_pkg.sv
// Shared widths, FSM state encoding and address helper for the my_svi slave.
package my_svi_pkg;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } svi_state_t;

    // True when addr selects an implemented register.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                           input int unsigned       depth);
        return (32'(addr) < depth);
    endfunction

endpackage

// File: rtl/my_svi.sv
// my_svi bus: single request/response handshake, master drives the request.
interface my_svi
    import my_svi_pkg::*;
;
    logic              valid;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic [DATA_W-1:0] rdata;

    modport slave (
        input  valid, write, addr, wdata,
        output ready, rdata
    );

    modport master (
        output valid, write, addr, wdata,
        input  ready, rdata
    );
endinterface

// File: rtl/my_svi_slave_regfile.sv
// Register storage: one write port, one registered read port that returns 0
// when not reading or when the address is beyond DEPTH.
module my_svi_slave_regfile
    import my_svi_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;
    logic              w_wr_hit;
    logic              w_rd_hit;

    assign w_wr_hit = i_we && addr_in_range(i_waddr, DEPTH);
    assign w_rd_hit = i_re && addr_in_range(i_raddr, DEPTH);

    // Storage array: cleared on reset, written only for in-range addresses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_hit) begin
            r_mem[i_waddr[IDX_W-1:0]] <= i_wdata;
        end
    end

    // Read register: holds data only for the cycle after a read strobe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (w_rd_hit) begin
            r_rdata <= r_mem[i_raddr[IDX_W-1:0]];
        end else begin
            r_rdata <= '0;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/my_svi_slave.sv
// my_svi responder: latches a request, inserts WAIT_CYCLES wait states,
// then presents a one-cycle registered response and commits writes.
module my_svi_slave
    import my_svi_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned DEPTH       = 16
) (
    input  logic        clk,
    input  logic        reset,
    my_svi.slave        my_svi_port,
    input  logic        count_clr,
    output logic [7:0]  count,
    output logic        busy
);

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [1:0]        r_rst_sync;
    logic              w_rst_n;
    svi_state_t        r_state;
    svi_state_t        w_state_next;
    logic              w_accept;
    logic [3:0]        r_wait_cnt;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_ready;
    logic              r_busy;
    logic [7:0]        r_count;
    logic              w_rd_write;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_re;
    logic              w_we;
    logic [DATA_W-1:0] w_rdata;

    // Reset synchronizer: asserts immediately, releases two edges later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rst_sync <= '0;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // FSM state register.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state: accept in IDLE, count down in WAIT, single-cycle RESP.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (my_svi_port.valid) begin
                    w_accept     = 1'b1;
                    w_state_next = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (r_wait_cnt == '0) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Request latch and wait-state counter.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wait_cnt <= '0;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            if (w_accept) begin
                r_write    <= my_svi_port.write;
                r_addr     <= my_svi_port.addr;
                r_wdata    <= my_svi_port.wdata;
                r_wait_cnt <= WAIT_LOAD;
            end else if (r_state == WAIT && r_wait_cnt != '0) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end
        end
    end

    // The read is launched on the edge entering RESP; with no wait states
    // that is the accept edge itself, so the live bus fields are used there.
    always_comb begin
        w_rd_write = r_write;
        w_rd_addr  = r_addr;
        if (r_state == IDLE) begin
            w_rd_write = my_svi_port.write;
            w_rd_addr  = my_svi_port.addr;
        end
        w_re = (w_state_next == RESP) && !w_rd_write;
        w_we = (r_state == RESP) && r_write;
    end

    my_svi_slave_regfile #(
        .DEPTH (DEPTH)
    ) u_regfile (
        .i_clk   (clk),
        .i_rst_n (w_rst_n),
        .i_we    (w_we),
        .i_waddr (r_addr),
        .i_wdata (r_wdata),
        .i_re    (w_re),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rdata)
    );

    // Registered handshake/status outputs derived from the next state.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_ready <= (w_state_next == RESP);
            r_busy  <= (w_state_next != IDLE);
        end
    end

    // Completion counter: clear has priority over an increment.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_count <= '0;
        end else if (count_clr) begin
            r_count <= '0;
        end else if (r_state == RESP) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign my_svi_port.ready = r_ready;
    assign my_svi_port.rdata = w_rdata;
    assign count             = r_count;
    assign busy              = r_busy;

endmodule

// File: tb/tb_my_svi_slave.sv
// Scoreboard bench for my_svi_slave: DUT 0 (WAIT_CYCLES=2, DEPTH=16) and
// DUT 1 (WAIT_CYCLES=0, DEPTH=8) share the clock.
module tb_my_svi_slave;

    localparam int WA = 2;
    localparam int WB = 0;

    typedef struct {
        logic [7:0]  data;
        bit          chk;
        int unsigned cyc;
    } exp_t;

    logic        clk = 1'b0;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    logic        valid_d [2];
    logic        write_d [2];
    logic [3:0]  addr_d  [2];
    logic [7:0]  wdata_d [2];
    logic        clr_d   [2];
    logic        rst_d   [2];

    logic        rdy [2];
    logic [7:0]  rd  [2];
    logic [7:0]  cnt [2];
    logic        bsy [2];

    exp_t q0[$];
    exp_t q1[$];

    my_svi ifa ();
    my_svi ifb ();

    assign ifa.valid = valid_d[0];
    assign ifa.write = write_d[0];
    assign ifa.addr  = addr_d[0];
    assign ifa.wdata = wdata_d[0];
    assign ifb.valid = valid_d[1];
    assign ifb.write = write_d[1];
    assign ifb.addr  = addr_d[1];
    assign ifb.wdata = wdata_d[1];
    assign rdy[0]    = ifa.ready;
    assign rd[0]     = ifa.rdata;
    assign rdy[1]    = ifb.ready;
    assign rd[1]     = ifb.rdata;

    my_svi_slave #(
        .WAIT_CYCLES (WA),
        .DEPTH       (16)
    ) u_dut_a (
        .clk         (clk),
        .reset       (rst_d[0]),
        .my_svi_port (ifa),
        .count_clr   (clr_d[0]),
        .count       (cnt[0]),
        .busy        (bsy[0])
    );

    my_svi_slave #(
        .WAIT_CYCLES (WB),
        .DEPTH       (8)
    ) u_dut_b (
        .clk         (clk),
        .reset       (rst_d[1]),
        .my_svi_port (ifb),
        .count_clr   (clr_d[1]),
        .count       (cnt[1]),
        .busy        (bsy[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wc(input int d);
        return (d == 0) ? WA : WB;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One transaction on DUT d; accepted at the next edge, bus fields are
    // scrambled afterwards. hold keeps valid high for a back-to-back request,
    // clr_end raises count_clr in the RESP cycle.
    task automatic txn(input int d, input bit wr, input logic [3:0] a,
                       input logic [7:0] wd, input logic [7:0] exp,
                       input bit hold, input bit clr_end);
        exp_t e;
        @(negedge clk);
        valid_d[d] = 1'b1;
        write_d[d] = wr;
        addr_d[d]  = a;
        wdata_d[d] = wd;
        @(posedge clk);
        #1;
        e.data = exp;
        e.chk  = !wr;
        e.cyc  = cyc + wc(d);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        if (!hold) valid_d[d] = 1'b0;
        write_d[d] = ~wr;
        addr_d[d]  = ~a;
        wdata_d[d] = ~wd;
        for (int i = 0; i <= wc(d); i++) begin
            if (clr_end && i == wc(d)) clr_d[d] = 1'b1;
            @(posedge clk);
            #1;
        end
        clr_d[d] = 1'b0;
    endtask

    task automatic idle_clear(input int d);
        @(negedge clk);
        clr_d[d] = 1'b1;
        @(posedge clk);
        #1;
        clr_d[d] = 1'b0;
    endtask

    // Monitor: pops an expectation each time ready is seen.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (rdy[d] === 1'b1) begin
                if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_ready dut%0d: got ready=1 at cycle %0d expected no response", d, cyc);
                end else begin
                    if (d == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    chk($sformatf("latency_dut%0d", d), cyc, e.cyc);
                    if (e.chk) chk($sformatf("rdata_dut%0d", d), {24'd0, rd[d]}, {24'd0, e.data});
                    chk($sformatf("busy_in_resp_dut%0d", d), {31'd0, bsy[d]}, 32'd1);
                end
            end else begin
                chk($sformatf("rdata_idle_dut%0d", d), {24'd0, rd[d]}, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            valid_d[d] = 1'b0;
            write_d[d] = 1'b0;
            addr_d[d]  = '0;
            wdata_d[d] = '0;
            clr_d[d]   = 1'b0;
            rst_d[d]   = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_d[0] = 1'b1;
        rst_d[1] = 1'b1;

        // Idle after reset.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("idle_ready_dut%0d", d), {31'd0, rdy[d]}, 32'd0);
                chk($sformatf("idle_busy_dut%0d", d), {31'd0, bsy[d]}, 32'd0);
                chk($sformatf("idle_count_dut%0d", d), {24'd0, cnt[d]}, 32'd0);
            end
        end

        // DUT 0: write then read back.
        txn(0, 1'b1, 4'd3, 8'hA5, 8'h00, 1'b0, 1'b0);
        txn(0, 1'b0, 4'd3, 8'h00, 8'hA5, 1'b0, 1'b0);
        chk("count_after_wr_rd", {24'd0, cnt[0]}, 32'd2);

        // DUT 0: reset during WAIT of a write aborts it.
        @(negedge clk);
        valid_d[0] = 1'b1;
        write_d[0] = 1'b1;
        addr_d[0]  = 4'd7;
        wdata_d[0] = 8'h3C;
        @(posedge clk);
        #1;
        valid_d[0] = 1'b0;
        @(posedge clk);
        #1;
        rst_d[0] = 1'b0;
        #1;
        chk("rst_async_busy", {31'd0, bsy[0]}, 32'd0);
        chk("rst_async_ready", {31'd0, rdy[0]}, 32'd0);
        chk("rst_async_count", {24'd0, cnt[0]}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_d[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("count_after_abort", {24'd0, cnt[0]}, 32'd0);
        txn(0, 1'b0, 4'd7, 8'h00, 8'h00, 1'b0, 1'b0);
        txn(0, 1'b0, 4'd3, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("count_after_abort_reads", {24'd0, cnt[0]}, 32'd2);

        // DUT 0: clear coinciding with a completion wins.
        txn(0, 1'b1, 4'd9, 8'h44, 8'h00, 1'b0, 1'b1);
        chk("clr_wins", {24'd0, cnt[0]}, 32'd0);
        txn(0, 1'b0, 4'd9, 8'h00, 8'h44, 1'b0, 1'b0);
        chk("count_after_clr", {24'd0, cnt[0]}, 32'd1);
        idle_clear(0);
        chk("idle_clear_a", {24'd0, cnt[0]}, 32'd0);

        // DUT 0: 256 back-to-back write/read pairs, count wraps to 0.
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            logic [3:0] a;
            v = 8'(i & 32'hFE) ^ 8'h5A;
            a = 4'((i / 2) % 16);
            if ((i % 2) == 0) txn(0, 1'b1, a, v, 8'h00, 1'b1, 1'b0);
            else              txn(0, 1'b0, a, 8'h00, v, 1'b1, 1'b0);
            if (i == 254) chk("count_255", {24'd0, cnt[0]}, 32'd255);
        end
        valid_d[0] = 1'b0;
        chk("count_wrap", {24'd0, cnt[0]}, 32'd0);

        // DUT 1: zero wait states.
        txn(1, 1'b1, 4'd1, 8'h11, 8'h00, 1'b0, 1'b0);
        txn(1, 1'b1, 4'd2, 8'h22, 8'h00, 1'b0, 1'b0);
        chk("count_b_writes", {24'd0, cnt[1]}, 32'd2);
        idle_clear(1);
        chk("idle_clear_b", {24'd0, cnt[1]}, 32'd0);
        txn(1, 1'b0, 4'd1, 8'h00, 8'h11, 1'b1, 1'b0);
        txn(1, 1'b0, 4'd2, 8'h00, 8'h22, 1'b1, 1'b0);
        txn(1, 1'b0, 4'd1, 8'h00, 8'h11, 1'b1, 1'b0);
        txn(1, 1'b0, 4'd2, 8'h00, 8'h22, 1'b1, 1'b0);
        valid_d[1] = 1'b0;
        chk("count_b2b", {24'd0, cnt[1]}, 32'd4);

        // DUT 1: addresses beyond DEPTH=8.
        txn(1, 1'b1, 4'd12, 8'h77, 8'h00, 1'b0, 1'b0);
        txn(1, 1'b0, 4'd12, 8'h00, 8'h00, 1'b0, 1'b0);
        txn(1, 1'b0, 4'd4,  8'h00, 8'h00, 1'b0, 1'b0);
        txn(1, 1'b1, 4'd7,  8'h99, 8'h00, 1'b0, 1'b0);
        txn(1, 1'b0, 4'd7,  8'h00, 8'h99, 1'b0, 1'b0);
        txn(1, 1'b0, 4'd8,  8'h00, 8'h00, 1'b0, 1'b0);
        chk("count_b_oor", {24'd0, cnt[1]}, 32'd10);

        repeat (5) @(posedge clk);
        #1;
        chk("pending_a", q0.size(), 32'd0);
        chk("pending_b", q1.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
